// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - round-robin packet arbiter merging NUM_REQ streams into one registered output
module rr_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        in_valid,
    output logic [NUM_REQ-1:0]        in_ready,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ-1:0]        in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_last,
    output logic                      locked
);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t         state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     lock_id;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     grant_next;
    logic [DATA_W-1:0]   sel_data;
    logic                load;
    logic                xfer;

    assign load   = !out_valid || out_ready;
    assign locked = (state == LOCKED);

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        grant = ptr;
        if (state == LOCKED) begin
            grant = lock_id;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (in_valid[(int'(ptr) + k) % NUM_REQ]) begin
                    grant = ID_W'((int'(ptr) + k) % NUM_REQ);
                end
            end
        end
    end

    // rst gates in_ready so nothing is offered as accepted while reset is held.
    always_comb begin
        in_ready = '0;
        if (!rst && load && (state == LOCKED || (|in_valid))) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer       = in_valid[grant] && in_ready[grant];
    assign sel_data   = in_data[int'(grant)*DATA_W +: DATA_W];
    assign grant_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNLOCKED;
            ptr       <= '0;
            lock_id   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_id    <= grant;
                out_last  <= in_last[grant];
                if (in_last[grant]) begin
                    state <= UNLOCKED;
                    ptr   <= grant_next;
                end else begin
                    state   <= LOCKED;
                    lock_id <= grant;
                end
            end else if (load) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - scenario and randomized bench for rr_stream_arbiter
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_id;
    logic           out_last;
    logic           locked;

    int total = 0;
    int bad   = 0;

    // reference state: what the output register and packet tracking should hold
    int           m_ptr;
    int           m_lock_id;
    bit           m_locked;
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_oid;
    bit           m_ol;

    int           e_grant;
    bit           e_xfer;
    logic [N-1:0] e_ready;

    rr_stream_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr = 0; m_lock_id = 0; m_locked = 0;
        m_ov = 0; m_od = '0; m_oid = 0; m_ol = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy);
        bit load;
        in_valid = v; in_last = l; out_ready = ordy;
        #1;
        load = !m_ov || ordy;
        e_grant = -1;
        if (m_locked) e_grant = m_lock_id;
        else for (int k = 0; k < N; k++)
            if (e_grant < 0 && v[(m_ptr + k) % N]) e_grant = (m_ptr + k) % N;
        e_ready = '0;
        if (load && e_grant >= 0 && !rst) e_ready[e_grant] = 1'b1;
        e_xfer = (e_grant >= 0) && v[e_grant] && e_ready[e_grant];
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_xfer) begin
            m_ov = 1; m_od = in_data[e_grant*W +: W]; m_oid = e_grant; m_ol = in_last[e_grant];
            if (in_last[e_grant]) begin
                m_locked = 0; m_ptr = (e_grant + 1) % N;
            end else begin
                m_locked = 1; m_lock_id = e_grant;
            end
        end else if (!m_ov || out_ready) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        rand_data();
        apply(4'hF, 4'hF, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (out_id !== '0) begin bad++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        advance();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_data();
            d = in_data[(i % 4)*W +: W];
            apply(4'hF, 4'hF, 1'b1);
            total++; if (in_ready !== 4'(1 << (i % 4))) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", i, in_ready, 4'(1 << (i % 4))); end
            advance();
            total++; if (out_valid !== 1'b1 || out_id !== IW'(i % 4)) begin bad++; $display("FAIL rr_beat%0d got valid=%b id=%0d exp valid=1 id=%0d", i, out_valid, out_id, i % 4); end
            total++; if (out_data !== d) begin bad++; $display("FAIL rr_data%0d got=%h exp=%h", i, out_data, d); end
        end
    endtask

    task automatic test_packet_lock();
        logic [W-1:0] pk [3];
        pk[0] = 32'hA0; pk[1] = 32'hA1; pk[2] = 32'hA2;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            rand_data();
            in_data[2*W +: W] = pk[b];
            apply((b == 0) ? 4'b0100 : 4'b0111, (b == 2) ? 4'b0100 : 4'b0000, 1'b1);
            total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL pkt_ready%0d got=%b exp=0100", b, in_ready); end
            advance();
            total++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== pk[b]) begin bad++; $display("FAIL pkt_beat%0d got v=%b id=%0d d=%h exp v=1 id=2 d=%h", b, out_valid, out_id, out_data, pk[b]); end
            total++; if (locked !== (b != 2) || out_last !== (b == 2)) begin bad++; $display("FAIL pkt_lock%0d got locked=%b last=%b exp locked=%b last=%b", b, locked, out_last, b != 2, b == 2); end
        end
        rand_data();
        apply(4'b0111, 4'b0111, 1'b1);
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL pkt_next_ready got=%b exp=0001", in_ready); end
        advance();
        total++; if (out_id !== 2'd0) begin bad++; $display("FAIL pkt_next_id got=%0d exp=0", out_id); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        rand_data();
        in_data[1*W +: W] = 32'h12345678;
        apply(4'b0010, 4'b0010, 1'b1);
        advance();
        total++; if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=12345678", out_valid, out_data); end
        for (int c = 0; c < 3; c++) begin
            rand_data();
            apply(4'hF, 4'hF, 1'b0);
            total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0000", c, in_ready); end
            advance();
            total++; if (out_valid !== 1'b1 || out_data !== 32'h12345678 || out_id !== 2'd1) begin bad++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d exp v=1 d=12345678 id=1", c, out_valid, out_data, out_id); end
        end
        rand_data();
        d = in_data[2*W +: W];
        apply(4'hF, 4'hF, 1'b1);
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        advance();
        total++; if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== d) begin bad++; $display("FAIL bp_next got v=%b id=%0d d=%h exp v=1 id=2 d=%h", out_valid, out_id, out_data, d); end
    endtask

    task automatic test_lock_bubble();
        logic [W-1:0] d;
        do_reset();
        rand_data();
        apply(4'b0010, 4'b0000, 1'b1);
        advance();
        total++; if (locked !== 1'b1 || out_id !== 2'd1) begin bad++; $display("FAIL bub_lock got locked=%b id=%0d exp locked=1 id=1", locked, out_id); end
        for (int c = 0; c < 2; c++) begin
            rand_data();
            apply(4'b0001, 4'b0001, 1'b1);
            total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL bub_ready%0d got=%b exp=0", c, in_ready[0]); end
            advance();
            total++; if (out_valid !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL bub_idle%0d got v=%b locked=%b exp v=0 locked=1", c, out_valid, locked); end
        end
        rand_data();
        d = in_data[1*W +: W];
        apply(4'b0011, 4'b0010, 1'b1);
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bub_resume_ready got=%b exp=0010", in_ready); end
        advance();
        total++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== d || locked !== 1'b0) begin bad++; $display("FAIL bub_resume got v=%b id=%0d d=%h locked=%b exp v=1 id=1 d=%h locked=0", out_valid, out_id, out_data, locked, d); end
    endtask

    task automatic test_async_reset();
        do_reset();
        rand_data();
        apply(4'b0100, 4'b0000, 1'b1);
        advance();
        apply(4'b0110, 4'b0000, 1'b0);
        total++; if (out_valid !== 1'b1 || locked !== 1'b1) begin bad++; $display("FAIL arst_pre got v=%b locked=%b exp v=1 locked=1", out_valid, locked); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (out_valid !== 1'b0 || locked !== 1'b0 || in_ready !== 4'b0) begin bad++; $display("FAIL arst_now got v=%b locked=%b rdy=%b exp v=0 locked=0 rdy=0000", out_valid, locked, in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        rand_data();
        apply(4'hF, 4'hF, 1'b1);
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL arst_first_ready got=%b exp=0001", in_ready); end
        advance();
        total++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_first got v=%b id=%0d exp v=1 id=0", out_valid, out_id); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_data();
            apply(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            total++;
            if (in_ready !== e_ready || out_valid !== m_ov || locked !== m_locked ||
                (m_ov && (out_data !== m_od || out_id !== IW'(m_oid) || out_last !== m_ol))) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL rand_c%0d got rdy=%b v=%b lk=%b d=%h id=%0d l=%b exp rdy=%b v=%b lk=%b d=%h id=%0d l=%b",
                             c, in_ready, out_valid, locked, out_data, out_id, out_last,
                             e_ready, m_ov, m_locked, m_od, m_oid, m_ol);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_lock_bubble();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting streams (2..8).
REQ-002 Parameter DATA_W, default 32, payload width per beat.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 Port in_ready  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-007 Port in_data  input  NUM_REQ*DATA_W  packed payloads; requester i at bits [i*DATA_W +: DATA_W].
REQ-008 Port in_last  input  NUM_REQ  per-requester end-of-packet flag.
REQ-009 Port out_valid  output  1  registered output beat valid.
REQ-010 Port out_ready  input  1  downstream accepts output beat.
REQ-011 Port out_data  output  DATA_W  registered output payload.
REQ-012 Port out_id  output  clog2(NUM_REQ)  index of requester that sourced the output beat.
REQ-013 Port out_last  output  1  registered end-of-packet flag.
REQ-014 Port locked  output  1  high while a packet is in progress (arbitration frozen).

Function
REQ-015 load = !out_valid || out_ready; the output register SHALL capture a new beat only when load is high.
REQ-016 When unlocked, grant SHALL be the first requester with in_valid=1 searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-017 When locked, grant SHALL be lock_id regardless of other in_valid bits.
REQ-018 in_ready[i] SHALL be 1 only when load=1 and i=grant (when unlocked, additionally some in_valid bit set); all other bits 0; combinational.
REQ-019 Transfer = in_valid[grant] && in_ready[grant]; on transfer next cycle out_valid=1, out_data=in_data[grant], out_id=grant, out_last=in_last[grant] (latency 1 cycle).
REQ-020 When load=1 and no transfer, out_valid SHALL go 0 at next edge; out_data/out_id/out_last hold.
REQ-021 When out_valid=1 and out_ready=0, out_valid, out_data, out_id, out_last SHALL hold stable and in_ready SHALL be all-zero.
REQ-022 Throughput: one beat per cycle sustained while out_ready=1 and the granted requester is valid, including across requester switches.
REQ-023 Lock state machine: UNLOCKED -> LOCKED on transfer with in_last=0 (lock_id<=grant); LOCKED -> UNLOCKED on transfer with in_last=1; otherwise hold.
REQ-024 Pointer: on transfer with in_last=1, ptr <= (grant+1) mod NUM_REQ; on any other cycle ptr holds.
REQ-025 While LOCKED with in_valid[lock_id]=0, no transfer occurs (bubble); other requesters SHALL NOT be granted.
REQ-026 Single-beat packet (in_last=1 on first beat) SHALL NOT enter LOCKED.
REQ-027 Simultaneous output drain and new capture in the same cycle SHALL not drop or duplicate a beat.
REQ-028 locked output SHALL equal the LOCKED state register.

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, out_id=0, out_last=0, locked=0, ptr=0, in_ready all-zero.
REQ-030 rst asserted mid-packet or with out_valid=1 SHALL discard the held beat and clear the lock immediately; first grant after release starts from requester 0.

Verification
REQ-031 Reset then in_valid=4'b1111, all in_last=1, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-032 Requester 2 sends 3-beat packet (data 0xA0,0xA1,0xA2, last on third) with requesters 0,1 also valid -> out_id=2 for three consecutive beats, locked=1 until after 0xA2, next grant is 3 (if valid) else 0.
REQ-033 out_ready=0 for 3 cycles holding out_data=0x12345678 -> out_valid/out_data stable, in_ready=0; on out_ready=1 next beat follows without loss.
REQ-034 Locked on requester 1, in_valid[1] drops 2 cycles while requester 0 valid -> no output beats and in_ready[0]=0 for those cycles; packet resumes on requester 1.
REQ-035 rst pulsed while locked with out_valid=1 -> out_valid=0, locked=0 asynchronously; after release requester 0 granted first.
